// File: rtl/tile_writeback_pkg.sv
// Shared constants and FSM encoding for the tile writeback engine.
package tile_writeback_pkg;

    localparam int TILE_DIM    = 32;
    localparam int TILE_PIXELS = TILE_DIM * TILE_DIM;
    localparam int PIX_W       = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } wb_state_t;

endpackage

// File: rtl/pixel_fifo.sv
// Small pixel FIFO with registered outputs; entries land in storage first and
// reach the output register on the following edge.
module pixel_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [W-1:0]               din,
    input  logic                       pop,
    output logic [W-1:0]               dout,
    output logic                       valid,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] mem_cnt;
    logic          load;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Refill the output register whenever it is empty or being consumed.
    assign load = (mem_cnt != '0) && (!valid || pop);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            mem_cnt <= '0;
            count   <= '0;
            valid   <= 1'b0;
            dout    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (load) begin
                rd_ptr <= ptr_inc(rd_ptr);
                dout   <= mem[rd_ptr];
                valid  <= 1'b1;
            end else if (pop) begin
                valid  <= 1'b0;
            end
            mem_cnt <= mem_cnt + CW'(push) - CW'(load);
            count   <= count + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: rtl/tile_writeback.sv
// Flushes one 32x32 RGB565 tile from the tile buffer to the framebuffer as
// row bursts, with credit-limited reads so returning data always has a slot.
//
// state    | meaning
// ST_IDLE  | waiting for start, done=1
// ST_READ  | issuing tile buffer reads in raster order
// ST_DRAIN | all reads issued, emptying pipeline and FIFO
module tile_writeback
    import tile_writeback_pkg::*;
#(
    parameter int SCREEN_W   = 640,
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [5:0]  tile_x,
    input  logic [5:0]  tile_y,
    input  logic [31:0] fb_base,
    output logic        rd_en,
    output logic [9:0]  rd_addr,
    input  logic [15:0] rd_q,
    output logic        wr_valid,
    input  logic        wr_ready,
    output logic [31:0] wr_addr,
    output logic [15:0] wr_data,
    output logic        wr_last,
    output logic        done
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [31:0] ROW_STEP   = 32'(2 * (SCREEN_W - TILE_DIM) + 2);
    localparam logic [31:0] TILE_ROW_B = 32'(2 * TILE_DIM * SCREEN_W);
    localparam logic [31:0] TILE_COL_B = 32'(2 * TILE_DIM);

    wb_state_t   state;
    wb_state_t   state_nx;
    logic [RD_LAT-1:0] vpipe;
    logic [7:0]  inflight;
    logic [9:0]  rd_cnt;
    logic [9:0]  beat_cnt;
    logic [CW-1:0] fifo_cnt;
    logic        push;
    logic        pop;
    logic        credit;
    logic        accept;
    logic [31:0] tile_off;

    assign push     = vpipe[RD_LAT-1];
    assign pop      = wr_valid && wr_ready;
    assign accept   = (state == ST_IDLE) && start;
    assign tile_off = 32'(tile_y) * TILE_ROW_B + 32'(tile_x) * TILE_COL_B;

    // A beat leaving this cycle frees its slot in time for a new read.
    assign credit  = (16'(inflight) + 16'(fifo_cnt)) < (16'(FIFO_DEPTH) + 16'(pop));
    assign rd_en   = (state == ST_READ) && credit;
    assign rd_addr = rd_cnt;
    assign wr_last = wr_valid && (beat_cnt[4:0] == 5'd31);

    always_comb begin
        state_nx = state;
        done     = 1'b0;
        case (state)
            ST_IDLE: begin
                done = 1'b1;
                if (start) state_nx = ST_READ;
            end
            ST_READ: begin
                if (rd_en && (rd_cnt == 10'(TILE_PIXELS - 1))) state_nx = ST_DRAIN;
            end
            ST_DRAIN: begin
                if ((fifo_cnt == '0) && (inflight == '0)) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            vpipe    <= '0;
            inflight <= '0;
            rd_cnt   <= '0;
            beat_cnt <= '0;
            wr_addr  <= '0;
        end else begin
            state    <= state_nx;
            vpipe    <= (vpipe << 1) | RD_LAT'(rd_en);
            inflight <= inflight + 8'(rd_en) - 8'(push);
            if (accept) begin
                rd_cnt   <= '0;
                beat_cnt <= '0;
                wr_addr  <= fb_base + tile_off;
            end else begin
                if (rd_en) rd_cnt <= rd_cnt + 10'd1;
                if (pop) begin
                    beat_cnt <= beat_cnt + 10'd1;
                    wr_addr  <= wr_addr + ((beat_cnt[4:0] == 5'd31) ? ROW_STEP : 32'd2);
                end
            end
        end
    end

    pixel_fifo #(
        .W     (PIX_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (rd_q),
        .pop   (pop),
        .dout  (wr_data),
        .valid (wr_valid),
        .count (fifo_cnt)
    );

endmodule

// File: tb/tb_tile_writeback.sv
// Directed bench for tile_writeback: a tile-buffer model feeds rd_q and a beat
// queue built from the address formula checks every write beat.
module tb_tile_writeback;

    localparam int W  = 640;
    localparam int RL = 2;
    localparam int FD = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  tile_x = '0;
    logic [5:0]  tile_y = '0;
    logic [31:0] fb_base = '0;
    logic        rd_en;
    logic [9:0]  rd_addr;
    logic [15:0] rd_q = 16'hDEAD;
    logic        wr_valid;
    logic        wr_ready = 1'b1;
    logic [31:0] wr_addr;
    logic [15:0] wr_data;
    logic        wr_last;
    logic        done;

    typedef struct packed {
        logic [31:0] addr;
        logic [15:0] data;
        logic        last;
    } beat_t;

    beat_t       exp_q[$];
    int          n_chk = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          t0 = 0;
    int          first_valid_cyc = -1;
    int          done_cyc = 0;
    int          beats_seen = 0;
    int          last_cnt = 0;
    int          ready_mode = 0;
    logic [15:0] seed = 16'h0000;
    logic [9:0]  rd_exp = '0;
    logic [31:0] got_addr [0:1023];
    logic        hist_v [0:RL];
    logic [9:0]  hist_a [0:RL];
    logic        prev_stall = 1'b0;
    beat_t       prev_beat;

    tile_writeback #(.SCREEN_W(W), .RD_LAT(RL), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst(rst), .start(start), .tile_x(tile_x), .tile_y(tile_y),
        .fb_base(fb_base), .rd_en(rd_en), .rd_addr(rd_addr), .rd_q(rd_q),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_last(wr_last), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] pat(input logic [9:0] a);
        return (16'(a) * 16'd40503) ^ seed;
    endfunction

    task automatic build(input int tx, input int ty, input logic [31:0] base);
        beat_t b;
        exp_q.delete();
        for (int py = 0; py < 32; py++) begin
            for (int px = 0; px < 32; px++) begin
                b.addr = base + 32'(2 * ((32 * ty + py) * W + 32 * tx + px));
                b.data = pat(10'(py * 32 + px));
                b.last = (px == 31);
                exp_q.push_back(b);
            end
        end
    endtask

    task automatic do_start(input int tx, input int ty, input logic [31:0] base, input bit enq);
        @(posedge clk); #1;
        if (enq) begin
            build(tx, ty, base);
            beats_seen = 0;
            last_cnt = 0;
            first_valid_cyc = -1;
            rd_exp = '0;
        end
        tile_x = 6'(tx);
        tile_y = 6'(ty);
        fb_base = base;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < budget);
        done_cyc = cyc;
        chk({tag, "_done_reached"}, 32'(done), 32'd1);
    endtask

    task automatic wait_beats(input int target, input int budget, input string tag);
        int n = 0;
        while (beats_seen < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_beats_reached"}, 32'(beats_seen >= target), 32'd1);
    endtask

    task automatic flush_post(input string tag);
        chk({tag, "_beats"}, 32'(beats_seen), 32'd1024);
        chk({tag, "_lasts"}, 32'(last_cnt), 32'd32);
        chk({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_done"},     32'(done),     32'd1);
        chk({tag, "_rd_en"},    32'(rd_en),    32'd0);
        chk({tag, "_rd_addr"},  32'(rd_addr),  32'd0);
        chk({tag, "_wr_valid"}, 32'(wr_valid), 32'd0);
        chk({tag, "_wr_last"},  32'(wr_last),  32'd0);
        chk({tag, "_wr_addr"},  wr_addr,       32'd0);
        chk({tag, "_wr_data"},  32'(wr_data),  32'd0);
    endtask

    // Tile buffer: data for a read issued in cycle t is presented in cycle t+RL.
    always @(negedge clk) begin
        for (int k = RL; k > 0; k--) begin
            hist_v[k] = hist_v[k-1];
            hist_a[k] = hist_a[k-1];
        end
        hist_v[0] = rd_en;
        hist_a[0] = rd_addr;
        rd_q = (hist_v[RL] === 1'b1) ? pat(hist_a[RL]) : 16'hDEAD;
        if (!rst && rd_en) begin
            chk("rd_addr_order", 32'(rd_addr), 32'(rd_exp));
            rd_exp = rd_exp + 10'd1;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (wr_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (prev_stall) begin
                chk("hold_addr", wr_addr, prev_beat.addr);
                chk("hold_data", 32'(wr_data), 32'(prev_beat.data));
                chk("hold_last", 32'(wr_last), 32'(prev_beat.last));
            end
            if (wr_valid) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL extra_beat: wr_valid with no beat expected, addr 0x%08h data 0x%04h", wr_addr, wr_data);
                end else begin
                    chk("beat_addr", wr_addr, exp_q[0].addr);
                    chk("beat_data", 32'(wr_data), 32'(exp_q[0].data));
                    chk("beat_last", 32'(wr_last), 32'(exp_q[0].last));
                    if (wr_ready) begin
                        if (beats_seen < 1024) got_addr[beats_seen] = wr_addr;
                        if (wr_last) last_cnt++;
                        beats_seen++;
                        void'(exp_q.pop_front());
                    end
                end
            end
            prev_stall = wr_valid && !wr_ready;
            prev_beat.addr = wr_addr;
            prev_beat.data = wr_data;
            prev_beat.last = wr_last;
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                1:       wr_ready = 1'($urandom_range(0, 1));
                2:       wr_ready = 1'b0;
                default: wr_ready = 1'b1;
            endcase
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int late_reads;
        int gaps;
        int run;
        for (int k = 0; k <= RL; k++) begin
            hist_v[k] = 1'b0;
            hist_a[k] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // Nominal tile with fixed timing.
        seed = 16'h1234;
        ready_mode = 0;
        do_start(1, 2, 32'h1000_0000, 1'b1);
        chk("model_addr0", exp_q[0].addr, 32'h1001_4040);
        chk("model_addr_row1", exp_q[32].addr, 32'h1001_4540);
        chk("model_data0", 32'(exp_q[0].data), 32'h1234);
        chk("model_data1", 32'(exp_q[1].data), 32'h8C03);
        wait_done(1200, "t1");
        chk("t1_first_valid_lat", 32'(first_valid_cyc - t0), 32'(RL + 2));
        chk("t1_done_lat", 32'(done_cyc - t0), 32'(1024 + RL + 3));
        chk("t1_addr0", got_addr[0], 32'h1001_4040);
        chk("t1_addr_row1", got_addr[32], 32'h1001_4540);
        flush_post("t1");

        // Random back-pressure.
        seed = 16'hA5A5;
        ready_mode = 1;
        do_start(3, 1, 32'h2000_0100, 1'b1);
        wait_done(5000, "t2");
        flush_post("t2");
        ready_mode = 0;

        // Long stall mid-row.
        seed = 16'h0F0F;
        do_start(0, 5, 32'h0004_0000, 1'b1);
        wait_beats(40, 200, "t3");
        ready_mode = 2;
        late_reads = 0;
        gaps = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (i >= 10 && rd_en) late_reads++;
            if (!wr_valid) gaps++;
        end
        chk("t3_reads_stalled", 32'(late_reads), 32'd0);
        chk("t3_valid_held", 32'(gaps), 32'd0);
        @(posedge clk); #1;
        ready_mode = 0;
        repeat (3) @(negedge clk);
        run = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (wr_valid && wr_ready) run++;
        end
        chk("t3_resume_no_gap", 32'(run), 32'd20);
        wait_done(1500, "t3");
        flush_post("t3");

        // Start during a flush must be ignored.
        seed = 16'h3C3C;
        do_start(2, 3, 32'h0800_0000, 1'b1);
        wait_beats(500, 700, "t4");
        do_start(7, 3, 32'h0800_0000, 1'b0);
        wait_done(1200, "t4");
        flush_post("t4");
        repeat (5) @(negedge clk);
        chk("t4_stays_idle", 32'(done), 32'd1);

        // Reset mid-flush, then a clean flush.
        seed = 16'h5555;
        ready_mode = 1;
        do_start(4, 0, 32'h0010_0000, 1'b1);
        wait_beats(300, 1500, "t5");
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_vals("t5_rst");
        seed = 16'h7777;
        do_start(4, 0, 32'h0010_0000, 1'b1);
        wait_done(5000, "t5");
        flush_post("t5");
        ready_mode = 0;

        // Address wrap at the top of the 32-bit space.
        seed = 16'h0001;
        do_start(0, 0, 32'hFFFF_FFF0, 1'b1);
        chk("model_wrap", exp_q[8].addr, 32'h0000_0000);
        wait_done(1200, "t6");
        chk("t6_addr7", got_addr[7], 32'hFFFF_FFFE);
        chk("t6_addr8", got_addr[8], 32'h0000_0000);
        flush_post("t6");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
